// File: rtl/if_fetch_if.sv
// Instruction-port handshake between the fetch stage (master) and the memory controller (slave).
interface if_fetch_if;
  logic        if_req_out;
  logic [31:0] inst_addr_out;
  logic [1:0]  mem_busy_in;
  logic        inst_done_in;
  logic [31:0] inst_in;

  modport master (
    output if_req_out, inst_addr_out,
    input  mem_busy_in, inst_done_in, inst_in
  );

  modport slave (
    input  if_req_out, inst_addr_out,
    output mem_busy_in, inst_done_in, inst_in
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: PC register, direct-mapped one-word-per-line I-cache, and a
// two-state miss handler that refills from the memory controller.
module if_fetch #(
  parameter int          INDEX_W  = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall_in,
  input  logic        branch_flag_in,
  input  logic [31:0] branch_target_in,
  if_fetch_if.master  mem,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid_out
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t             state;
  logic [31:0]        pc;
  logic [LINES-1:0]   line_valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               fill;
  logic [31:0]        branch_pc;
  logic               unused_bits;

  assign pc_index   = pc[INDEX_W+1:2];
  assign pc_tag     = pc[31:INDEX_W+2];
  assign fill_index = mem.inst_addr_out[INDEX_W+1:2];
  assign fill_tag   = mem.inst_addr_out[31:INDEX_W+2];
  assign hit        = line_valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign fill       = rdy_in && (state == WAIT_MEM) && mem.inst_done_in;
  assign branch_pc  = {branch_target_in[31:2], 2'b00};

  // Only data-port ownership (bit 0) matters to the fetch side.
  assign unused_bits = ^{branch_target_in[1:0], mem.mem_busy_in[1]};

  // NOTE: the tag/data arrays are deliberately not reset; line_valid alone
  // decides whether a line is usable, so the arrays map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (fill && !rst_in) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mem.inst_in;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch of the FSM reads the pre-edge values of pc, state and the cache.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      pc                <= RESET_PC;
      line_valid        <= '0;
      mem.if_req_out    <= 1'b0;
      mem.inst_addr_out <= '0;
      pc_out            <= '0;
      inst_out          <= '0;
      inst_valid_out    <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (branch_flag_in) begin
            pc             <= branch_pc;
            inst_valid_out <= 1'b0;
          end else if (stall_in) begin
            // hold everything
          end else if (hit) begin
            inst_out       <= data_mem[pc_index];
            pc_out         <= pc;
            inst_valid_out <= 1'b1;
            pc             <= pc + 32'd4;
          end else if (!mem.mem_busy_in[0]) begin
            mem.if_req_out    <= 1'b1;
            mem.inst_addr_out <= pc;
            inst_valid_out    <= 1'b0;
            state             <= WAIT_MEM;
          end else begin
            inst_valid_out <= 1'b0;
          end
        end

        WAIT_MEM: begin
          // The controller cannot abort a word, so a redirect only retargets pc
          // and the outstanding fill still lands at the latched address.
          if (mem.inst_done_in) begin
            line_valid[fill_index] <= 1'b1;
            mem.if_req_out         <= 1'b0;
            state                  <= IDLE;
          end
          if (branch_flag_in) begin
            pc             <= branch_pc;
            inst_valid_out <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a fixed-latency controller model plus a vector
// table for hit/stall/ready behaviour and hand sequences for miss corner cases.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_in;
  logic        branch_flag_in;
  logic [31:0] branch_target_in;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid_out;

  if_fetch_if mem_bus ();

  if_fetch #(.INDEX_W(6), .RESET_PC(32'h0)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .stall_in         (stall_in),
    .branch_flag_in   (branch_flag_in),
    .branch_target_in (branch_target_in),
    .mem              (mem_bus.master),
    .pc_out           (pc_out),
    .inst_out         (inst_out),
    .inst_valid_out   (inst_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        rdy;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 | {a[19:0], 12'h000};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    tick();
    while (!inst_valid_out && n < 20) begin
      tick();
      n++;
    end
    check({name, "_valid"}, inst_valid_out, 1);
    check({name, "_pc"}, pc_out, exp_pc);
    check({name, "_inst"}, inst_out, mem_word(exp_pc));
  endtask

  // Controller model: done pulse on the 4th cycle of a held request.
  initial begin
    int cnt;
    cnt = 0;
    mem_bus.inst_done_in = 1'b0;
    mem_bus.inst_in      = '0;
    forever begin
      @(posedge clk_in);
      #2;
      mem_bus.inst_done_in = 1'b0;
      if (mem_bus.if_req_out === 1'b1) begin
        cnt++;
        if (cnt == 4) begin
          mem_bus.inst_done_in = 1'b1;
          mem_bus.inst_in      = mem_word(mem_bus.inst_addr_out);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    logic valid_seen;
    int   n;

    vecs[0]  = '{1'b1, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'hC, mem_word(32'hC)};
    vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0, mem_word(32'h0)};
    vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h4, mem_word(32'h4)};
    vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h8, mem_word(32'h8)};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hC, mem_word(32'hC)};
    vecs[5]  = '{1'b1, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'hC, mem_word(32'hC)};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0, mem_word(32'h0)};
    vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h4, mem_word(32'h4)};
    vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h4, mem_word(32'h4)};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h4, mem_word(32'h4)};
    vecs[10] = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4, mem_word(32'h4)};
    vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h8, mem_word(32'h8)};
    vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hC, mem_word(32'hC)};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    stall_in = 1'b0;
    branch_flag_in = 1'b0;
    branch_target_in = '0;
    mem_bus.mem_busy_in = 2'b00;

    // Reset state
    tick();
    tick();
    check("rst_req", mem_bus.if_req_out, 0);
    check("rst_addr", mem_bus.inst_addr_out, 0);
    check("rst_valid", inst_valid_out, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_inst", inst_out, 0);

    // Cold miss at RESET_PC, then sequential misses
    rst_in = 1'b0;
    tick();
    check("miss0_req", mem_bus.if_req_out, 1);
    check("miss0_addr", mem_bus.inst_addr_out, 32'h0);
    tick();
    tick();
    check("miss0_req_held", mem_bus.if_req_out, 1);
    check("miss0_addr_held", mem_bus.inst_addr_out, 32'h0);
    wait_valid("fetch0", 32'h0);
    tick();
    check("miss4_req", mem_bus.if_req_out, 1);
    check("miss4_addr", mem_bus.inst_addr_out, 32'h4);
    check("miss4_valid", inst_valid_out, 0);
    wait_valid("fetch4", 32'h4);
    tick();
    check("miss8_req", mem_bus.if_req_out, 1);
    check("miss8_addr", mem_bus.inst_addr_out, 32'h8);

    // Redirect to 0x102 while 0x8 is outstanding
    branch_flag_in = 1'b1;
    branch_target_in = 32'h102;
    tick();
    branch_flag_in = 1'b0;
    valid_seen = inst_valid_out;
    n = 0;
    while (mem_bus.if_req_out && n < 20) begin
      check("wait8_addr_held", mem_bus.inst_addr_out, 32'h8);
      tick();
      valid_seen |= inst_valid_out;
      n++;
    end
    check("wait8_done_timeout", mem_bus.if_req_out, 0);
    tick();
    valid_seen |= inst_valid_out;
    check("redir_no_valid", valid_seen, 0);
    check("redir_req", mem_bus.if_req_out, 1);
    check("redir_addr", mem_bus.inst_addr_out, 32'h100);
    wait_valid("fetch100", 32'h100);

    // Conflict: 0x100 evicted line 0, so 0x0 misses again
    branch_flag_in = 1'b1;
    branch_target_in = 32'h0;
    tick();
    branch_flag_in = 1'b0;
    check("br0_valid", inst_valid_out, 0);
    check("br0_req", mem_bus.if_req_out, 0);
    tick();
    check("conflict_req", mem_bus.if_req_out, 1);
    check("conflict_addr", mem_bus.inst_addr_out, 32'h0);
    wait_valid("refetch0", 32'h0);
    tick();
    check("hit4_req", mem_bus.if_req_out, 0);
    check("hit4_pc", pc_out, 32'h4);
    tick();
    check("hit8_req", mem_bus.if_req_out, 0);
    check("hit8_valid", inst_valid_out, 1);
    check("hit8_pc", pc_out, 32'h8);
    check("hit8_inst", inst_out, mem_word(32'h8));
    tick();
    check("missC_req", mem_bus.if_req_out, 1);
    check("missC_addr", mem_bus.inst_addr_out, 32'hC);
    wait_valid("fetchC", 32'hC);

    // Warm-cache loop, stall and ready-freeze vectors
    for (int i = 0; i < 13; i++) begin
      branch_flag_in   = vecs[i].br;
      branch_target_in = vecs[i].tgt;
      stall_in         = vecs[i].stall;
      rdy_in           = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_req", i), mem_bus.if_req_out, vecs[i].exp_req);
      check($sformatf("vec%0d_valid", i), inst_valid_out, vecs[i].exp_valid);
      check($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
      check($sformatf("vec%0d_inst", i), inst_out, vecs[i].exp_inst);
    end
    branch_flag_in = 1'b0;
    branch_target_in = '0;
    stall_in = 1'b0;
    rdy_in = 1'b1;

    // Data port owns RAM for 3 cycles on the 0x10 miss
    mem_bus.mem_busy_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("busy%0d_req", i), mem_bus.if_req_out, 0);
      check($sformatf("busy%0d_valid", i), inst_valid_out, 0);
    end
    mem_bus.mem_busy_in = 2'b00;
    tick();
    check("unbusy_req", mem_bus.if_req_out, 1);
    check("unbusy_addr", mem_bus.inst_addr_out, 32'h10);

    // Reset in the middle of the 0x10 miss
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    check("midrst_req", mem_bus.if_req_out, 0);
    check("midrst_valid", inst_valid_out, 0);
    check("midrst_pc_out", pc_out, 0);
    rst_in = 1'b0;
    tick();
    check("postrst_req", mem_bus.if_req_out, 1);
    check("postrst_addr", mem_bus.inst_addr_out, 32'h0);
    wait_valid("postrst_fetch0", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
